// File: rtl/ifc_pkg.sv
// ifc_pkg: shared types and constants for the instruction fetch controller.
package ifc_pkg;

    // Byte distance between consecutive instruction words
    localparam int unsigned PC_STEP = 4;

    // Width of the optional performance counters
    localparam int unsigned CNT_W = 32;

    // One prefetch queue entry: the fetched word and its address + 4
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } ifc_entry_t;

endpackage

// File: rtl/ifc_prefetch_q.sv
// ifc_prefetch_q: 2-entry register queue feeding the ID stage.
// Slot 0 is always the head. When the queue is empty the head outputs show
// the most recently popped entry (zero after reset).
module ifc_prefetch_q
    import ifc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  ifc_entry_t din,
    output ifc_entry_t head,
    output logic [1:0] count
);

    ifc_entry_t q0_q, q0_d;
    ifc_entry_t q1_q, q1_d;
    ifc_entry_t last_q, last_d;
    logic [1:0] count_q, count_d;

    // Next-state: push/pop bookkeeping, clear empties the queue (a same-cycle pop still retires)
    always_comb begin
        q0_d    = q0_q;
        q1_d    = q1_q;
        last_d  = last_q;
        count_d = count_q;
        if (pop) begin
            last_d = q0_q;
        end
        if (clear) begin
            count_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        q0_d = din;
                    end else begin
                        q1_d = din;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        q0_d = q1_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind the surviving entry
                    if (count_q == 2'd1) begin
                        q0_d = din;
                    end else begin
                        q0_d = q1_q;
                        q1_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q0_q    <= '0;
            q1_q    <= '0;
            last_q  <= '0;
            count_q <= 2'd0;
        end else begin
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // Head shows the live entry, or the last retired one while empty
    always_comb begin
        head  = (count_q != 2'd0) ? q0_q : last_q;
        count = count_q;
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: IF-stage fetch sequencer. Owns the fetch PC, drives the
// combinational instruction memory, buffers words in a 2-entry prefetch queue
// and redirects on taken branches.
// Optional feature: define IFC_PERF_CNT_EN to add fetch/stall/flush counters.
module inst_fetch_ctrl
    import ifc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [31:0]       mem_addr,
    input  logic [31:0]       mem_instr,
    input  logic              br_taken,
    input  logic [31:0]       br_addr,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_instr,
`ifdef IFC_PERF_CNT_EN
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic [31:0]       id_pc
);

    if (DEPTH != 2) begin : gen_depth_chk
        $error("inst_fetch_ctrl: only DEPTH == 2 is supported");
    end

    logic [31:0] fpc_q, fpc_d;
    logic [31:0] fpc_inc;
    logic [1:0]  count;
    logic        push, pop;
    ifc_entry_t  din, head;

    // Target alignment bits are dropped
    logic unused_br_lsb;
    assign unused_br_lsb = ^br_addr[1:0];

    // Handshake and fetch decisions; a branch suppresses the fetch of the wrong-path word
    always_comb begin
        fpc_inc  = fpc_q + 32'(PC_STEP);
        id_valid = (count != 2'd0);
        pop      = id_valid && id_ready;
        push     = ((count < 2'd2) || pop) && !br_taken;
        mem_addr = fpc_q;
        din      = '{pc4: fpc_inc, instr: mem_instr};
        id_instr = head.instr;
        id_pc    = head.pc4;
    end

    // Next fetch PC: redirect wins over sequential advance; wraps modulo 2^32
    always_comb begin
        fpc_d = fpc_q;
        if (br_taken) begin
            fpc_d = {br_addr[31:2], 2'b00};
        end else if (push) begin
            fpc_d = fpc_inc;
        end
    end

    // Fetch PC register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc_q <= RESET_PC;
        end else begin
            fpc_q <= fpc_d;
        end
    end

    ifc_prefetch_q u_prefetch_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (br_taken),
        .din   (din),
        .head  (head),
        .count (count)
    );

`ifdef IFC_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

    // Free-running event counters, wrap on overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push) begin
                fetch_cnt_q <= fetch_cnt_q + 1'b1;
            end
            if (id_valid && !id_ready) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (br_taken) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
